// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised datapath register file.
// Holds the clear-sequencer state encoding, the default geometry and the
// high-impedance fill value used for disabled read ports.
// Optional feature macro (consumed by register_file_param): REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned RF_DEF_WIDTH  = 10;
    localparam int unsigned RF_DEF_DEPTH  = 4;
    localparam int unsigned RF_DEF_NUM_RD = 2;

    // Per-bit fill for a read port whose enable is low.
    localparam logic RF_Z = 1'bz;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer and write qualifier for register_file_param.
// All state advances on the falling edge of CLKb; RSTb is async active-low.
// Ports:
//   CLKb, RSTb    clock (falling edge active) and reset
//   enw, clr      raw write enable and clear request from the control FSM
//   busy          clear sequence in progress (registered)
//   wr_drop       one-cycle pulse after a discarded write (registered)
//   cnt           register index being cleared this cycle (registered)
//   wr_accept_c   the current write will land in storage on this edge
//   clr_en_c      storage entry cnt is zeroed on this edge
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = RF_DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLKb,
    input  logic          RSTb,
    input  logic          enw,
    input  logic          clr,
    output logic          busy,
    output logic          wr_drop,
    output logic [AW-1:0] cnt,
    output logic          wr_accept_c,
    output logic          clr_en_c
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          wr_drop_q, wr_drop_d;

    // State register
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q   <= RF_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state and write qualification
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        wr_drop_d   = 1'b0;
        wr_accept_c = 1'b0;
        clr_en_c    = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr) begin
                    // Clear has priority; a coincident write is lost.
                    state_d   = RF_CLEAR;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    wr_drop_d = enw;
                end else begin
                    wr_accept_c = enw;
                end
            end
            RF_CLEAR: begin
                clr_en_c  = 1'b1;
                wr_drop_d = enw;
                // DEPTH is a power of two, so the increment wraps to 0 at the end.
                cnt_d     = AW'(cnt_q + 1'b1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RF_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = RF_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;
    assign cnt     = cnt_q;

endmodule

// File: rtl/register_file_param.sv
// Parametrised datapath register file: DEPTH x WIDTH storage, one write
// port, NUM_RD independently enabled tri-state read ports and a sequenced
// clear-all (one register per falling edge while BUSY is high).
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write's
// data to any enabled read port addressing WRA in the same cycle.
// Ports:
//   CLKb, RSTb  clock (falling edge active), async active-low reset
//   D, ENW, WRA write data, enable, address
//   ENR, RDA    per-port read enables, packed read addresses (AW per port)
//   Q           packed read data (WIDTH per port), high-Z when disabled
//   CLR         start a clear-all sequence
//   BUSY        clear in progress
//   WR_DROP     one-cycle pulse after a discarded write
module register_file_param
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = RF_DEF_WIDTH,
    parameter int unsigned DEPTH  = RF_DEF_DEPTH,
    parameter int unsigned NUM_RD = RF_DEF_NUM_RD,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                    CLKb,
    input  logic                    RSTb,
    input  logic [WIDTH-1:0]        D,
    input  logic                    ENW,
    input  logic [AW-1:0]           WRA,
    input  logic [NUM_RD-1:0]       ENR,
    input  logic [NUM_RD*AW-1:0]    RDA,
    output logic [NUM_RD*WIDTH-1:0] Q,
    input  logic                    CLR,
    output logic                    BUSY,
    output logic                    WR_DROP
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    cnt;
    logic             wr_accept_c;
    logic             clr_en_c;

    regfile_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .CLKb        (CLKb),
        .RSTb        (RSTb),
        .enw         (ENW),
        .clr         (CLR),
        .busy        (BUSY),
        .wr_drop     (WR_DROP),
        .cnt         (cnt),
        .wr_accept_c (wr_accept_c),
        .clr_en_c    (clr_en_c)
    );

    // Storage update: clear sequencer owns the array while it runs
    always_comb begin
        mem_d = mem_q;
        if (clr_en_c) begin
            mem_d[cnt] = '0;
        end else if (wr_accept_c) begin
            mem_d[WRA] = D;
        end
    end

    // Storage array
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    rda_c;
        logic [WIDTH-1:0] rd_data_c;

        assign rda_c = RDA[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        // Forward only writes that will actually land; nothing forwards under reset.
        assign rd_data_c = (RSTb && wr_accept_c && (rda_c == WRA)) ? D : mem_q[rda_c];
`else
        assign rd_data_c = mem_q[rda_c];
`endif

        assign Q[i*WIDTH +: WIDTH] = ENR[i] ? rd_data_c : {WIDTH{RF_Z}};
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default 10x4x2 instance and a 16x8x3
// instance driven side by side against an array-based reference model.
// Disabled read ports are pulled up, so a high-Z port reads as all ones.
module tb_register_file_param;

    logic clk;
    logic rst;

    // Stimulus, index 0 = default instance, index 1 = 16x8x3 instance
    logic [15:0] t_d   [2];
    logic        t_enw [2];
    logic [2:0]  t_wra [2];
    logic        t_clr [2];
    logic [2:0]  t_enr [2];
    logic [2:0]  t_rda [2][3];

    wire  [19:0] qa;
    wire  [47:0] qb;
    logic        busy_a, drop_a, busy_b, drop_b;

    pullup (qa);
    pullup (qb);

    // Reference model state
    logic [15:0] mm    [2][8];
    bit          mbusy [2];
    int          midx  [2];
    bit          mdrop [2];

    int checks = 0;
    int errors = 0;

    register_file_param u_dut_a (
        .CLKb    (clk),
        .RSTb    (rst),
        .D       (t_d[0][9:0]),
        .ENW     (t_enw[0]),
        .WRA     (t_wra[0][1:0]),
        .ENR     (t_enr[0][1:0]),
        .RDA     ({t_rda[0][1][1:0], t_rda[0][0][1:0]}),
        .Q       (qa),
        .CLR     (t_clr[0]),
        .BUSY    (busy_a),
        .WR_DROP (drop_a)
    );

    register_file_param #(
        .WIDTH  (16),
        .DEPTH  (8),
        .NUM_RD (3)
    ) u_dut_b (
        .CLKb    (clk),
        .RSTb    (rst),
        .D       (t_d[1]),
        .ENW     (t_enw[1]),
        .WRA     (t_wra[1]),
        .ENR     (t_enr[1]),
        .RDA     ({t_rda[1][2], t_rda[1][1], t_rda[1][0]}),
        .Q       (qb),
        .CLR     (t_clr[1]),
        .BUSY    (busy_b),
        .WR_DROP (drop_b)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] wmask(input int w);
        return 16'((32'h1 << w) - 1);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int width_of(input int k);
        return (k == 0) ? 10 : 16;
    endfunction

    task automatic reset_models();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) mm[k][a] = '0;
            mbusy[k] = 1'b0;
            midx[k]  = 0;
            mdrop[k] = 1'b0;
        end
    endtask

    // Effect of one falling edge on the model
    task automatic update(input int k);
        if (!rst) begin
            for (int a = 0; a < 8; a++) mm[k][a] = '0;
            mbusy[k] = 1'b0;
            midx[k]  = 0;
            mdrop[k] = 1'b0;
        end else if (mbusy[k]) begin
            mm[k][midx[k]] = '0;
            mdrop[k] = t_enw[k];
            midx[k]++;
            if (midx[k] == depth_of(k)) begin
                mbusy[k] = 1'b0;
                midx[k]  = 0;
            end
        end else if (t_clr[k]) begin
            mbusy[k] = 1'b1;
            midx[k]  = 0;
            mdrop[k] = t_enw[k];
        end else begin
            mdrop[k] = 1'b0;
            if (t_enw[k]) mm[k][t_wra[k]] = t_d[k] & wmask(width_of(k));
        end
    endtask

    function automatic logic [15:0] exp_q(input int k, input int p);
        logic [15:0] m;
        m = wmask(width_of(k));
        if (!t_enr[k][p]) return m;
`ifdef REGFILE_BYPASS_EN
        if (rst && !mbusy[k] && !t_clr[k] && t_enw[k] && (t_wra[k] == t_rda[k][p]))
            return t_d[k] & m;
`endif
        return mm[k][t_rda[k][p]];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        chk("a_busy", 16'(busy_a), 16'(mbusy[0]));
        chk("a_wr_drop", 16'(drop_a), 16'(mdrop[0]));
        chk("b_busy", 16'(busy_b), 16'(mbusy[1]));
        chk("b_wr_drop", 16'(drop_b), 16'(mdrop[1]));
        for (int p = 0; p < 2; p++)
            chk($sformatf("a_q%0d", p), 16'(qa[p*10 +: 10]), exp_q(0, p));
        for (int p = 0; p < 3; p++)
            chk($sformatf("b_q%0d", p), qb[p*16 +: 16], exp_q(1, p));
    endtask

    task automatic tick();
        @(negedge clk);
        update(0);
        update(1);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        #1;
        check_all();
        tick();
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            t_d[k]   = '0;
            t_enw[k] = 1'b0;
            t_wra[k] = '0;
            t_clr[k] = 1'b0;
            t_enr[k] = '0;
            for (int p = 0; p < 3; p++) t_rda[k][p] = '0;
        end
    endtask

    task automatic write_a(input logic [2:0] a, input logic [15:0] v);
        t_enw[0] = 1'b1;
        t_wra[0] = a;
        t_d[0]   = v;
        cyc();
        t_enw[0] = 1'b0;
    endtask

    task automatic fill_a();
        for (int a = 0; a < 4; a++) write_a(3'(a), 16'(10'h155 + a * 37));
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        reset_models();
        tick();

        // Reset: enabled ports read 0, disabled ports float
        t_enr[0] = 3'b011;
        t_rda[0][0] = 3'd0;
        t_rda[0][1] = 3'd1;
        cyc();
        chk("a_q0_reset_const", 16'(qa[9:0]), 16'h0);
        t_enr[0] = 3'b000;
        cyc();
        rst = 1'b1;
        cyc();

        // Write 2A5 to addr 3 with a same-cycle read, then read it back
        t_enr[0] = 3'b010;
        t_rda[0][1] = 3'd3;
        t_enw[0] = 1'b1;
        t_wra[0] = 3'd3;
        t_d[0] = 16'h02A5;
        cyc();
        t_enw[0] = 1'b0;
        #1;
        chk("a_q1_after_write_const", 16'(qa[19:10]), 16'h02A5);
        cyc();

        // Fill then clear; sweep reads across the zeroing window
        t_enr[0] = 3'b011;
        fill_a();
        t_clr[0] = 1'b1;
        cyc();
        t_clr[0] = 1'b1;   // held high into CLEAR: must not restart
        for (int i = 0; i < 6; i++) begin
            t_rda[0][0] = 3'(i % 4);
            t_rda[0][1] = 3'((i + 1) % 4);
            cyc();
            t_clr[0] = 1'b0;
        end

        // Write during CLEAR is dropped
        fill_a();
        t_clr[0] = 1'b1;
        cyc();
        t_clr[0] = 1'b0;
        cyc();
        t_enw[0] = 1'b1;
        t_wra[0] = 3'd3;
        t_d[0] = 16'h03FF;
        cyc();
        t_enw[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_rda[0][0] = 3'd3;
            t_rda[0][1] = 3'(i);
            cyc();
        end

        // Write together with CLR is dropped
        fill_a();
        t_enw[0] = 1'b1;
        t_clr[0] = 1'b1;
        t_wra[0] = 3'd2;
        t_d[0] = 16'h0123;
        cyc();
        t_enw[0] = 1'b0;
        t_clr[0] = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        // Reset two cycles into a clear, then a write succeeds
        fill_a();
        t_clr[0] = 1'b1;
        cyc();
        t_clr[0] = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        reset_models();
        for (int i = 0; i < 4; i++) begin
            t_rda[0][0] = 3'(i);
            cyc();
        end
        rst = 1'b1;
        cyc();
        write_a(3'd1, 16'h0321);
        t_rda[0][0] = 3'd1;
        cyc();

        // Wide instance: BEEF at 7, three ports on distinct addresses
        t_enw[1] = 1'b1;
        t_wra[1] = 3'd7;
        t_d[1] = 16'hBEEF;
        cyc();
        t_wra[1] = 3'd2;
        t_d[1] = 16'h1234;
        cyc();
        t_wra[1] = 3'd5;
        t_d[1] = 16'hA5A5;
        cyc();
        t_enw[1] = 1'b0;
        t_enr[1] = 3'b111;
        t_rda[1][0] = 3'd7;
        t_rda[1][1] = 3'd2;
        t_rda[1][2] = 3'd5;
        #1;
        chk("b_q0_beef_const", qb[15:0], 16'hBEEF);
        cyc();
        t_rda[1][1] = 3'd7;
        cyc();

        // Randomised traffic on both instances
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            if (!rst) reset_models();
            for (int k = 0; k < 2; k++) begin
                t_enw[k] = 1'($urandom_range(0, 1));
                t_clr[k] = ($urandom_range(0, 15) == 0);
                t_d[k]   = 16'($urandom);
                t_wra[k] = 3'($urandom_range(0, depth_of(k) - 1));
                t_enr[k] = 3'($urandom);
                if (k == 0) t_enr[k][2] = 1'b0;
                for (int p = 0; p < 3; p++)
                    t_rda[k][p] = (k == 0 && p == 2) ? 3'd0 : 3'($urandom_range(0, depth_of(k) - 1));
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
